// File: rtl/demux_l1a4.sv
// Four-lane time-slot demultiplexer: splits an interleaved byte stream on clk_4f
// back into four parallel lanes, publishing one complete group every four slots.
module demux_l1a4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic             valid_out0,
  output logic             valid_out1,
  output logic             valid_out2,
  output logic             valid_out3,
  output logic             group_strobe,
  output logic             misalign
);

  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] cap_q [4];
  logic [WIDTH-1:0] cap_d [4];
  logic [3:0]       cap_v_q, cap_v_d;
  logic [WIDTH-1:0] data_out_q [4];
  logic [WIDTH-1:0] data_out_d [4];
  logic [3:0]       valid_out_q, valid_out_d;
  logic             strobe_q, strobe_d;
  logic             misalign_q, misalign_d;

  logic [1:0]       eff_slot;
  logic [WIDTH-1:0] din_masked;

  always_comb begin
    eff_slot    = sync ? 2'd0 : slot_q;
    din_masked  = valid_in ? data_in : '0;
    cap_d       = cap_q;
    cap_v_d     = cap_v_q;
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    strobe_d    = 1'b0;
    misalign_d  = sync && (slot_q != 2'd0);

    // A sync mid-group throws away whatever was gathered after slot 0.
    if (misalign_d) begin
      for (int i = 1; i < 4; i++) begin
        cap_d[i]   = '0;
        cap_v_d[i] = 1'b0;
      end
    end

    cap_d[eff_slot]   = din_masked;
    cap_v_d[eff_slot] = valid_in;
    slot_d            = eff_slot + 2'd1;

    // Lane 3 bypasses the capture bank so the group publishes on its last slot.
    if (eff_slot == 2'd3) begin
      for (int i = 0; i < 3; i++) begin
        data_out_d[i]  = cap_q[i];
        valid_out_d[i] = cap_v_q[i];
      end
      data_out_d[3]  = din_masked;
      valid_out_d[3] = valid_in;
      strobe_d       = 1'b1;
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      slot_q      <= 2'd0;
      cap_v_q     <= 4'd0;
      valid_out_q <= 4'd0;
      strobe_q    <= 1'b0;
      misalign_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cap_q[i]      <= '0;
        data_out_q[i] <= '0;
      end
    end else begin
      slot_q      <= slot_d;
      cap_v_q     <= cap_v_d;
      valid_out_q <= valid_out_d;
      strobe_q    <= strobe_d;
      misalign_q  <= misalign_d;
      for (int i = 0; i < 4; i++) begin
        cap_q[i]      <= cap_d[i];
        data_out_q[i] <= data_out_d[i];
      end
    end
  end

  assign data_out0    = data_out_q[0];
  assign data_out1    = data_out_q[1];
  assign data_out2    = data_out_q[2];
  assign data_out3    = data_out_q[3];
  assign valid_out0   = valid_out_q[0];
  assign valid_out1   = valid_out_q[1];
  assign valid_out2   = valid_out_q[2];
  assign valid_out3   = valid_out_q[3];
  assign group_strobe = strobe_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_demux_l1a4.sv
// Directed, table-driven bench for demux_l1a4; expected lane values are
// hand-computed per cycle, with hand-written reset sequences around the table.
module tb_demux_l1a4;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       sync;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       group_strobe;
  logic       misalign;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic        s;
    logic        strb;
    logic        mis;
    logic [31:0] od;
    logic [3:0]  ov;
  } vec_t;

  vec_t vecs[$];

  demux_l1a4 #(.WIDTH(8)) dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .sync         (sync),
    .data_out0    (data_out0),
    .data_out1    (data_out1),
    .data_out2    (data_out2),
    .data_out3    (data_out3),
    .valid_out0   (valid_out0),
    .valid_out1   (valid_out1),
    .valid_out2   (valid_out2),
    .valid_out3   (valid_out3),
    .group_strobe (group_strobe),
    .misalign     (misalign)
  );

  always #5 clk_4f = ~clk_4f;

  function automatic logic [31:0] lanesData();
    return {data_out0, data_out1, data_out2, data_out3};
  endfunction

  function automatic logic [3:0] lanesValid();
    return {valid_out0, valid_out1, valid_out2, valid_out3};
  endfunction

  function automatic void addVec(logic [7:0] d, logic v, logic s, logic strb,
                                 logic mis, logic [31:0] od, logic [3:0] ov);
    vec_t t;
    t.d = d; t.v = v; t.s = s; t.strb = strb; t.mis = mis; t.od = od; t.ov = ov;
    vecs.push_back(t);
  endfunction

  // Drive one slot, then settle just after the rising edge that consumes it.
  task automatic applyStimulus(input logic [7:0] d, input logic v, input logic s);
    data_in  = d;
    valid_in = v;
    sync     = s;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic strb, input logic mis,
                          input logic [31:0] od, input logic [3:0] ov);
    checkOutput({tag, " strobe"}, {31'd0, group_strobe}, {31'd0, strb});
    checkOutput({tag, " misalign"}, {31'd0, misalign}, {31'd0, mis});
    checkOutput({tag, " data"}, lanesData(), od);
    checkOutput({tag, " valid"}, {28'd0, lanesValid()}, {28'd0, ov});
  endtask

  initial begin
    reset    = 1'b0;
    data_in  = 8'hAA;
    valid_in = 1'b1;
    sync     = 1'b0;

    // Nominal group
    addVec(8'hEE, 1, 0, 0, 0, 32'h00000000, 4'b0000);
    addVec(8'h01, 1, 0, 0, 0, 32'h00000000, 4'b0000);
    addVec(8'hFF, 1, 0, 0, 0, 32'h00000000, 4'b0000);
    addVec(8'hFD, 1, 0, 1, 0, 32'hEE01FFFD, 4'b1111);
    // Invalid slot 2 is masked to zero
    addVec(8'h10, 1, 0, 0, 0, 32'hEE01FFFD, 4'b1111);
    addVec(8'h11, 1, 0, 0, 0, 32'hEE01FFFD, 4'b1111);
    addVec(8'h55, 0, 0, 0, 0, 32'hEE01FFFD, 4'b1111);
    addVec(8'h13, 1, 0, 1, 0, 32'h10110013, 4'b1101);
    // Continuous stream 00..0B
    addVec(8'h00, 1, 0, 0, 0, 32'h10110013, 4'b1101);
    addVec(8'h01, 1, 0, 0, 0, 32'h10110013, 4'b1101);
    addVec(8'h02, 1, 0, 0, 0, 32'h10110013, 4'b1101);
    addVec(8'h03, 1, 0, 1, 0, 32'h00010203, 4'b1111);
    addVec(8'h04, 1, 0, 0, 0, 32'h00010203, 4'b1111);
    addVec(8'h05, 1, 0, 0, 0, 32'h00010203, 4'b1111);
    addVec(8'h06, 1, 0, 0, 0, 32'h00010203, 4'b1111);
    addVec(8'h07, 1, 0, 1, 0, 32'h04050607, 4'b1111);
    addVec(8'h08, 1, 0, 0, 0, 32'h04050607, 4'b1111);
    addVec(8'h09, 1, 0, 0, 0, 32'h04050607, 4'b1111);
    addVec(8'h0A, 1, 0, 0, 0, 32'h04050607, 4'b1111);
    addVec(8'h0B, 1, 0, 1, 0, 32'h08090A0B, 4'b1111);
    // Sync during slot 2 realigns; sync byte lands on lane 0
    addVec(8'h20, 1, 0, 0, 0, 32'h08090A0B, 4'b1111);
    addVec(8'h21, 1, 0, 0, 0, 32'h08090A0B, 4'b1111);
    addVec(8'h22, 1, 1, 0, 1, 32'h08090A0B, 4'b1111);
    addVec(8'h23, 1, 0, 0, 0, 32'h08090A0B, 4'b1111);
    addVec(8'h24, 1, 0, 0, 0, 32'h08090A0B, 4'b1111);
    addVec(8'h25, 1, 0, 1, 0, 32'h22232425, 4'b1111);
    // Sync on slot 0 is harmless
    addVec(8'h30, 1, 1, 0, 0, 32'h22232425, 4'b1111);
    addVec(8'h31, 1, 0, 0, 0, 32'h22232425, 4'b1111);
    addVec(8'h32, 1, 0, 0, 0, 32'h22232425, 4'b1111);
    addVec(8'h33, 1, 0, 1, 0, 32'h30313233, 4'b1111);
    // Sync on slot 3 wins over completion
    addVec(8'h40, 1, 0, 0, 0, 32'h30313233, 4'b1111);
    addVec(8'h41, 1, 0, 0, 0, 32'h30313233, 4'b1111);
    addVec(8'h42, 1, 0, 0, 0, 32'h30313233, 4'b1111);
    addVec(8'h43, 1, 1, 0, 1, 32'h30313233, 4'b1111);
    addVec(8'h44, 1, 0, 0, 0, 32'h30313233, 4'b1111);
    addVec(8'h45, 1, 0, 0, 0, 32'h30313233, 4'b1111);
    addVec(8'h46, 1, 0, 1, 0, 32'h43444546, 4'b1111);
    // All-invalid group still completes with zeros
    addVec(8'h77, 0, 0, 0, 0, 32'h43444546, 4'b1111);
    addVec(8'h77, 0, 0, 0, 0, 32'h43444546, 4'b1111);
    addVec(8'h77, 0, 0, 0, 0, 32'h43444546, 4'b1111);
    addVec(8'h77, 0, 0, 1, 0, 32'h00000000, 4'b0000);
    // Non-zero group ahead of the mid-group reset
    addVec(8'h60, 1, 0, 0, 0, 32'h00000000, 4'b0000);
    addVec(8'h61, 1, 0, 0, 0, 32'h00000000, 4'b0000);
    addVec(8'h62, 1, 0, 0, 0, 32'h00000000, 4'b0000);
    addVec(8'h63, 1, 0, 1, 0, 32'h60616263, 4'b1111);

    // Reset hold with active-looking input
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hAA, 1'b1, 1'b0);
      checkAll($sformatf("reset_hold%0d", i), 1'b0, 1'b0, 32'h0, 4'h0);
    end
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, vecs[i].v, vecs[i].s);
      checkAll($sformatf("vec%0d", i), vecs[i].strb, vecs[i].mis, vecs[i].od, vecs[i].ov);
    end

    // Mid-group reset: slots 0 and 1 captured, then reset drops between edges
    applyStimulus(8'h50, 1'b1, 1'b0);
    applyStimulus(8'h51, 1'b1, 1'b0);
    checkAll("pre_reset", 1'b0, 1'b0, 32'h60616263, 4'b1111);
    reset = 1'b0;
    #1;
    checkAll("async_clear", 1'b0, 1'b0, 32'h0, 4'h0);
    applyStimulus(8'h52, 1'b1, 1'b0);
    checkAll("in_reset", 1'b0, 1'b0, 32'h0, 4'h0);
    reset = 1'b1;
    applyStimulus(8'h70, 1'b1, 1'b0);
    checkAll("restart0", 1'b0, 1'b0, 32'h0, 4'h0);
    applyStimulus(8'h71, 1'b1, 1'b0);
    checkAll("restart1", 1'b0, 1'b0, 32'h0, 4'h0);
    applyStimulus(8'h72, 1'b1, 1'b0);
    checkAll("restart2", 1'b0, 1'b0, 32'h0, 4'h0);
    applyStimulus(8'h73, 1'b1, 1'b0);
    checkAll("restart3", 1'b1, 1'b0, 32'h70717273, 4'b1111);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkAll("restart_hold", 1'b0, 1'b0, 32'h70717273, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
